// File: rtl/rtc_tx_secuencia.sv
// RTC-to-display transmitter: on frame_start reads 11 BCD registers, converts them to binary
// and streams a pad beat plus 11 data beats. Define TX_GAP_EN to insert an idle cycle after each beat.
module rtc_tx_secuencia #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [7:0]  PAD_VALUE = 8'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_start,
    output logic       rd_req,
    output logic [7:0] rd_addr,
    input  logic       rd_ack,
    input  logic [7:0] rd_data,
    output logic [7:0] datoRTC,
    output logic       inicioSecuencia,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, DONE} state_t;

    state_t          state;
    logic [3:0]      index;
    logic [3:0]      beat;
    logic [CW-1:0]   cnt;
    logic [7:0]      regs_buf [1:11];
`ifdef TX_GAP_EN
    logic            gap;
`endif

    logic [7:0] masked;
    logic [3:0] tens;
    logic [3:0] units;
    logic       bcd_bad;
    logic [7:0] bin;
    logic [7:0] beat_val;
    logic       rd_done;

    function automatic logic [7:0] addr_of(input logic [3:0] i);
        case (i)
            4'd1:    addr_of = 8'h21;
            4'd2:    addr_of = 8'h22;
            4'd3:    addr_of = 8'h23;
            4'd4:    addr_of = 8'h24;
            4'd5:    addr_of = 8'h25;
            4'd6:    addr_of = 8'h26;
            4'd7:    addr_of = 8'h27;
            4'd8:    addr_of = 8'h28;
            4'd9:    addr_of = 8'h41;
            4'd10:   addr_of = 8'h42;
            4'd11:   addr_of = 8'h43;
            default: addr_of = 8'h00;
        endcase
    endfunction

    // Hour registers carry a 12/24 flag in bit 6, so they get the narrower mask.
    always_comb begin
        masked   = rd_data & (((index == 4'd3) || (index == 4'd11)) ? 8'h3F : 8'h7F);
        tens     = masked[7:4];
        units    = masked[3:0];
        bcd_bad  = (tens > 4'd9) || (units > 4'd9);
        bin      = bcd_bad ? 8'd0 : ({4'd0, tens} * 8'd10 + {4'd0, units});
        beat_val = (beat == 4'd0) ? PAD_VALUE : regs_buf[beat];
        rd_done  = rd_ack || (cnt == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            rd_req          <= 1'b0;
            rd_addr         <= 8'd0;
            datoRTC         <= 8'd0;
            inicioSecuencia <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            err             <= 1'b0;
            index           <= 4'd0;
            beat            <= 4'd0;
            cnt             <= '0;
            for (int i = 1; i <= 11; i++) regs_buf[i] <= 8'd0;
`ifdef TX_GAP_EN
            gap             <= 1'b0;
`endif
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state   <= REQ;
                        index   <= 4'd1;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                        rd_req  <= 1'b1;
                        rd_addr <= addr_of(4'd1);
                    end
                end
                REQ: begin
                    rd_req  <= 1'b1;
                    rd_addr <= addr_of(index);
                    cnt     <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (rd_done) begin
                        rd_req <= 1'b0;
                        cnt    <= '0;
                        // A timed-out read keeps the previous frame's value.
                        if (rd_ack) begin
                            regs_buf[index] <= bin;
                            if (bcd_bad) err <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        if (index == 4'd11) begin
                            state <= SEND;
                            beat  <= 4'd0;
`ifdef TX_GAP_EN
                            gap   <= 1'b0;
`endif
                        end else begin
                            index <= index + 4'd1;
                            state <= REQ;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SEND: begin
`ifdef TX_GAP_EN
                    if (gap) begin
                        inicioSecuencia <= 1'b0;
                        gap             <= 1'b0;
                    end else begin
                        gap             <= 1'b1;
`endif
                        datoRTC         <= beat_val;
                        inicioSecuencia <= 1'b1;
                        if (beat == 4'd11) state <= DONE;
                        else               beat  <= beat + 4'd1;
`ifdef TX_GAP_EN
                    end
`endif
                end
                DONE: begin
                    inicioSecuencia <= 1'b0;
                    frame_done      <= 1'b1;
                    busy            <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rtc_tx_secuencia.sv
// Randomized bench for rtc_tx_secuencia: a responder answers reads, a frame-level model predicts the beats.
module tb_rtc_tx_secuencia;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       rd_req;
    logic [7:0] rd_addr;
    logic       rd_ack = 1'b0;
    logic [7:0] rd_data = 8'd0;
    logic [7:0] datoRTC;
    logic       inicioSecuencia;
    logic       busy;
    logic       frame_done;
    logic       err;

`ifdef TX_GAP_EN
    localparam int GAP = 2;
`else
    localparam int GAP = 1;
`endif

    rtc_tx_secuencia dut (
        .clk(clk), .reset(reset), .frame_start(frame_start),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .datoRTC(datoRTC), .inicioSecuencia(inicioSecuencia), .busy(busy),
        .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] tbl [12];
    logic [7:0] data [12];
    bit         noack [12];
    int         model_buf [12];
    int         lat = 2;
    logic [7:0] addr_q [$];
    int         beat_q [$];
    int         beat_cyc [$];

    task automatic chk(input string tag, input int got, input int want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    function automatic int idx_of(input logic [7:0] a);
        for (int k = 1; k <= 11; k++) if (tbl[k] == a) return k;
        return 0;
    endfunction

    // BCD value as the display expects it; -1 marks an invalid digit.
    function automatic int conv(input int k, input logic [7:0] d);
        int m, t, u;
        m = int'(d) & (((k == 3) || (k == 11)) ? 'h3F : 'h7F);
        t = m / 16;
        u = m % 16;
        if (t > 9 || u > 9) return -1;
        return t * 10 + u;
    endfunction

    // Responder: ack each request lat cycles after it rises, or let it time out.
    initial begin
        int k;
        forever begin
            @(negedge clk);
            if (rd_req && !reset) begin
                k = idx_of(rd_addr);
                addr_q.push_back(rd_addr);
                if (k != 0 && !noack[k]) begin
                    repeat (lat) @(negedge clk);
                    rd_ack  = 1'b1;
                    rd_data = data[k];
                    @(negedge clk);
                    rd_ack  = 1'b0;
                end else begin
                    while (rd_req) @(negedge clk);
                end
            end
        end
    end

    task automatic run_frame(input string name, input int L, input bit extra, input bit chk_lat);
        int  exp_beats [12];
        bit  exp_err;
        int  v, c0, fd, busy_low, busy_fd, err_fd, steps;
        bit  p2;
        exp_err = 1'b0;
        exp_beats[0] = 0;
        for (int k = 1; k <= 11; k++) begin
            if (noack[k]) begin
                v = model_buf[k];
                exp_err = 1'b1;
            end else begin
                v = conv(k, data[k]);
                if (v < 0) begin v = 0; exp_err = 1'b1; end
            end
            exp_beats[k] = v;
            model_buf[k] = v;
        end
        lat = L;
        addr_q.delete(); beat_q.delete(); beat_cyc.delete();
        fd = -1; busy_low = 0; busy_fd = 1; err_fd = 0; steps = 0; p2 = 1'b0;
        @(negedge clk);
        frame_start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        frame_start = 1'b0;
        while (fd < 0 && steps < 8000) begin
            if (inicioSecuencia) begin
                beat_q.push_back(int'(datoRTC));
                beat_cyc.push_back(cyc);
            end
            if (frame_done) begin
                fd = cyc; busy_fd = busy; err_fd = err;
            end else if (!busy) busy_low++;
            frame_start = extra && (steps == 5 || (beat_q.size() == 3 && !p2));
            if (beat_q.size() == 3) p2 = 1'b1;
            @(negedge clk);
            steps++;
        end
        frame_start = 1'b0;
        chk({name, "_frame_done_seen"}, int'(fd >= 0), 1);
        chk({name, "_num_reads"}, addr_q.size(), 11);
        for (int k = 0; k < 11 && k < addr_q.size(); k++)
            chk({name, "_rd_addr"}, addr_q[k], tbl[k + 1]);
        chk({name, "_num_beats"}, beat_q.size(), 12);
        for (int i = 0; i < 12 && i < beat_q.size(); i++) begin
            chk({name, "_beat"}, beat_q[i], exp_beats[i]);
            if (i > 0) chk({name, "_beat_spacing"}, beat_cyc[i] - beat_cyc[i - 1], GAP);
        end
        if (beat_q.size() == 12 && fd >= 0)
            chk({name, "_done_after_last"}, fd - beat_cyc[11], 1);
        if (chk_lat && beat_q.size() > 0)
            chk({name, "_latency"}, beat_cyc[0] - c0, 1 + 11 * (L + 2));
        chk({name, "_err"}, err_fd, int'(exp_err));
        chk({name, "_busy_gaps"}, busy_low, 0);
        chk({name, "_busy_at_done"}, busy_fd, 0);
        chk({name, "_done_one_cycle"}, frame_done, 0);
        repeat (2) @(negedge clk);
        chk({name, "_err_sticky"}, err, int'(exp_err));
    endtask

    initial begin
        int steps;
        tbl = '{8'h00, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28, 8'h41, 8'h42, 8'h43};
        for (int k = 0; k < 12; k++) begin noack[k] = 1'b0; model_buf[k] = 0; data[k] = 8'h00; end

        repeat (3) @(negedge clk);
        chk("reset_ctrl", {rd_req, inicioSecuencia, busy, frame_done, err}, 0);
        chk("reset_addr", rd_addr, 0);
        chk("reset_dato", datoRTC, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        data = '{8'h00, 8'h45, 8'h30, 8'h23, 8'h17, 8'h03, 8'h24, 8'h05, 8'h12, 8'h09, 8'h00, 8'h01};
        run_frame("nominal", 2, 1'b0, 1'b1);

        data[2] = 8'h5A;
        data[3] = 8'h92;
        run_frame("bad_bcd", 2, 1'b0, 1'b1);

        noack[4] = 1'b1;
        run_frame("timeout", 2, 1'b0, 1'b0);
        noack[4] = 1'b0;

        for (int r = 0; r < 4; r++) begin
            for (int k = 1; k <= 11; k++) begin
                logic [3:0] t, u;
                t = 4'($urandom_range(0, 5));
                u = 4'($urandom_range(0, 9));
                if ((r % 2) == 1 && $urandom_range(0, 7) == 0) u = 4'($urandom_range(10, 15));
                data[k] = {t, u} | ($urandom_range(0, 1) ? 8'h80 : 8'h00);
                if ((k == 3 || k == 11) && $urandom_range(0, 1)) data[k] = data[k] | 8'h40;
            end
            run_frame("random", $urandom_range(1, 4), r == 1, 1'b1);
        end

        // Abort in the middle of SEND.
        for (int k = 1; k <= 11; k++) data[k] = 8'h11;
        lat = 2;
        beat_q.delete();
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        steps = 0;
        while (beat_q.size() < 7 && steps < 3000) begin
            if (inicioSecuencia) beat_q.push_back(int'(datoRTC));
            if (beat_q.size() < 7) begin @(negedge clk); steps++; end
        end
        chk("abort_reached_beat6", beat_q.size(), 7);
        #2 reset = 1'b1;
        #1;
        chk("abort_async_ctrl", {rd_req, inicioSecuencia, busy, frame_done, err}, 0);
        chk("abort_async_dato", datoRTC, 0);
        chk("abort_async_addr", rd_addr, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) model_buf[k] = 0;
        repeat (3) @(negedge clk);
        chk("abort_idle_quiet", {inicioSecuencia, busy}, 0);

        for (int k = 1; k <= 11; k++) data[k] = 8'h00;
        run_frame("zero", 3, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
